// File: rtl/parking_pkg.sv
// Shared types and default sizes for the parking slot scheduler.
package parking_pkg;

  localparam int unsigned NUM_SLOTS_DEF = 4;
  localparam int unsigned SLOT_W_DEF    = 2;
  localparam int unsigned TIME_W_DEF    = 11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENTRY_OP = 3'd1,
    ST_EXIT_OP  = 3'd2,
    ST_DONE     = 3'd3,
    ST_RELEASE  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/parking_slot_scheduler_slot_alloc.sv
// Lowest-index free slot finder over the occupancy bitmap.
module slot_alloc
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int unsigned SLOT_W    = SLOT_W_DEF
) (
  input  logic [NUM_SLOTS-1:0] occupied,
  output logic [SLOT_W-1:0]    free_idx_c,
  output logic                 any_free_c
);

  // Scan from the top down so the lowest free index wins.
  always_comb begin
    free_idx_c = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!occupied[i]) free_idx_c = SLOT_W'(i);
    end
  end

  assign any_free_c = ~&occupied;

endmodule

// File: rtl/parking_slot_scheduler.sv
// Entry/exit arbiter with per-slot entry timestamps and parked-duration output.
module parking_slot_scheduler
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int unsigned SLOT_W    = SLOT_W_DEF,
  parameter int unsigned TIME_W    = TIME_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [TIME_W-1:0]    timer,
  input  logic                 entry_req,
  input  logic                 exit_req,
  input  logic [SLOT_W-1:0]    exit_slot,
  output logic                 entry_ack,
  output logic [SLOT_W-1:0]    entry_slot,
  output logic                 entry_full,
  output logic                 exit_ack,
  output logic [TIME_W-1:0]    exit_duration,
  output logic                 exit_err,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic [SLOT_W:0]      free_count
);

  sched_state_t      state, state_nxt;
  logic              prio_exit, prio_exit_nxt;
  logic              svc_exit, svc_exit_nxt;
  logic [TIME_W-1:0] stamp [NUM_SLOTS];
  logic [SLOT_W-1:0] free_idx_c;
  logic              any_free_c;
  logic              exit_hit_c;

  slot_alloc #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_slot_alloc (
    .occupied   (occupied),
    .free_idx_c (free_idx_c),
    .any_free_c (any_free_c)
  );

  // Out-of-range slot numbers are treated as unoccupied.
  assign exit_hit_c = (32'(exit_slot) < NUM_SLOTS) && occupied[exit_slot];

  // State, round-robin flag and serviced-side register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      prio_exit <= 1'b1;
      svc_exit  <= 1'b0;
    end else begin
      state     <= state_nxt;
      prio_exit <= prio_exit_nxt;
      svc_exit  <= svc_exit_nxt;
    end
  end

  // Arbitration and sequencing; RELEASE holds until the serviced request drops.
  always_comb begin
    state_nxt     = state;
    prio_exit_nxt = prio_exit;
    svc_exit_nxt  = svc_exit;
    unique case (state)
      ST_IDLE: begin
        if (entry_req && exit_req) begin
          state_nxt     = prio_exit ? ST_EXIT_OP : ST_ENTRY_OP;
          svc_exit_nxt  = prio_exit;
          prio_exit_nxt = ~prio_exit;
        end else if (exit_req) begin
          state_nxt    = ST_EXIT_OP;
          svc_exit_nxt = 1'b1;
        end else if (entry_req) begin
          state_nxt    = ST_ENTRY_OP;
          svc_exit_nxt = 1'b0;
        end
      end
      ST_ENTRY_OP, ST_EXIT_OP: state_nxt = ST_DONE;
      ST_DONE:                 state_nxt = ST_RELEASE;
      ST_RELEASE: begin
        if (!(svc_exit ? exit_req : entry_req)) state_nxt = ST_IDLE;
      end
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Slot bank, result registers and one-cycle acks (high while in DONE).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_ack     <= 1'b0;
      exit_ack      <= 1'b0;
      entry_slot    <= '0;
      entry_full    <= 1'b0;
      exit_duration <= '0;
      exit_err      <= 1'b0;
      occupied      <= '0;
      free_count    <= (SLOT_W+1)'(NUM_SLOTS);
      for (int i = 0; i < int'(NUM_SLOTS); i++) stamp[i] <= '0;
    end else begin
      entry_ack <= (state == ST_ENTRY_OP);
      exit_ack  <= (state == ST_EXIT_OP);
      if (state == ST_ENTRY_OP) begin
        if (any_free_c) begin
          stamp[free_idx_c]    <= timer;
          occupied[free_idx_c] <= 1'b1;
          free_count           <= free_count - (SLOT_W+1)'(1);
          entry_slot           <= free_idx_c;
          entry_full           <= 1'b0;
        end else begin
          entry_full <= 1'b1;
        end
      end
      if (state == ST_EXIT_OP) begin
        if (exit_hit_c) begin
          exit_duration       <= timer - stamp[exit_slot];
          occupied[exit_slot] <= 1'b0;
          free_count          <= free_count + (SLOT_W+1)'(1);
          exit_err            <= 1'b0;
        end else begin
          exit_duration <= '0;
          exit_err      <= 1'b1;
        end
      end
    end
  end

endmodule
